// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, the buffered write-request type and the
// source-register hit compare used by the arbiter.
package regfile_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wr_req_t;
    // Register 0 never carries a real dependency, so it never hits.
    function automatic logic src_hit(input wr_req_t e, input logic v, input logic [REG_ADDR_W-1:0] r);
        return v && (r != '0) && (e.rd == r);
    endfunction
endpackage

// File: rtl/regfile_wr_fifo.sv
// regfile_wr_fifo: 2-entry in-order buffer for multicycle writes, with both
// physical slots and their valid bits exposed for dependency compares.
module regfile_wr_fifo
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  wr_req_t    i_din,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_count,
    output wr_req_t    o_head,
    output wr_req_t    o_ent0,
    output wr_req_t    o_ent1,
    output logic [1:0] o_vld
);
    logic [1:0] r_count;
    logic       r_wptr;
    logic       r_rptr;
    wr_req_t    r_mem [2];
    logic       w_push;
    logic       w_pop;

    assign o_full  = r_count == 2'd2;
    assign o_empty = r_count == 2'd0;
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_ent0  = r_mem[0];
    assign o_ent1  = r_mem[1];
    assign o_vld[0] = o_full || (r_count == 2'd1 && !r_rptr);
    assign o_vld[1] = o_full || (r_count == 2'd1 && r_rptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Storage needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// writeback and buffered multicycle results, forcing the buffer after starvation.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wbValid,
    input  logic [REG_ADDR_W-1:0] wbReg,
    input  logic [DATA_W-1:0]     wbData,
    output logic                  wbStall,
    input  logic                  mcValid,
    input  logic [REG_ADDR_W-1:0] mcReg,
    input  logic [DATA_W-1:0]     mcData,
    output logic                  mcReady,
    input  logic [REG_ADDR_W-1:0] readRegister1,
    input  logic [REG_ADDR_W-1:0] readRegister2,
    output logic                  pendingHit1,
    output logic                  pendingHit2,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0]     writeData
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_count;
    logic [1:0]    w_vld;
    wr_req_t       w_head;
    wr_req_t       w_ent0;
    wr_req_t       w_ent1;
    wr_req_t       w_wb_req;
    wr_req_t       w_win;
    logic          w_force;
    logic          w_mc_win;
    logic          w_wb_win;
    logic          w_push;

    regfile_wr_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_mc_win),
        .i_din   ('{rd: mcReg, data: mcData}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head),
        .o_ent0  (w_ent0),
        .o_ent1  (w_ent1),
        .o_vld   (w_vld)
    );

    // The reset cycle is treated as having no winner so nothing is written.
    assign w_wb_req = '{rd: wbReg, data: wbData};
    assign w_force  = !reset && !w_empty && (r_starve == SW'(STARVE_LIMIT));
    assign w_mc_win = w_force || (!reset && !wbValid && !w_empty);
    assign w_wb_win = !reset && wbValid && !w_force;
    assign w_win    = w_mc_win ? w_head : w_wb_win ? w_wb_req : '0;

    assign regWrite      = (w_mc_win || w_wb_win) && (w_win.rd != '0);
    assign writeRegister = w_win.rd;
    assign writeData     = w_win.data;
    assign wbStall       = wbValid && w_force;
    assign mcReady       = !w_full;
    assign w_push        = mcValid && mcReady && !reset;

    assign pendingHit1 = !reset && (src_hit(w_ent0, w_vld[0], readRegister1) || src_hit(w_ent1, w_vld[1], readRegister1));
    assign pendingHit2 = !reset && (src_hit(w_ent0, w_vld[0], readRegister2) || src_hit(w_ent1, w_vld[1], readRegister2));

    always_ff @(posedge clk) begin
        if (reset || w_mc_win || w_empty) r_starve <= '0;
        else if (w_wb_win && r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table for the documented scenarios,
// then random traffic checked against a queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 0;
    logic        reset, wbValid, mcValid;
    logic [4:0]  wbReg, mcReg, readRegister1, readRegister2;
    logic [31:0] wbData, mcData;
    logic        wbStall, mcReady, pendingHit1, pendingHit2, regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData), .wbStall(wbStall),
        .mcValid(mcValid), .mcReg(mcReg), .mcData(mcData), .mcReady(mcReady),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .pendingHit1(pendingHit1), .pendingHit2(pendingHit2),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, wv, mv, cd, ch;
        logic [4:0]  wr, mr, r1, r2;
        logic [31:0] wd, md;
        logic        e_we, e_st, e_rdy, e_h1, e_h2;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    vec_t  vt [$];
    ent_t  q [$];
    int    starve = 0;
    int    total = 0, bad = 0, cyc = 0;
    logic        m_win, m_fifo, m_we, m_st, m_rdy, m_h1, m_h2;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs from the arbitration rules applied to the queue.
    task automatic model_eval();
        logic frc, wbw;
        frc    = !reset && q.size() > 0 && starve == LIMIT;
        m_fifo = frc || (!reset && !wbValid && q.size() > 0);
        wbw    = !reset && wbValid && !frc;
        m_win  = m_fifo || wbw;
        m_wr   = m_fifo ? q[0].r : wbw ? wbReg : 5'd0;
        m_wd   = m_fifo ? q[0].d : wbw ? wbData : 32'd0;
        m_we   = m_win && m_wr != 0;
        m_st   = wbValid && frc;
        m_rdy  = q.size() < 2;
        m_h1   = 0;
        m_h2   = 0;
        foreach (q[i]) begin
            if (readRegister1 != 0 && q[i].r == readRegister1) m_h1 = 1;
            if (readRegister2 != 0 && q[i].r == readRegister2) m_h2 = 1;
        end
    endtask

    task automatic model_step(input logic push_ok);
        if (reset) begin
            q.delete();
            starve = 0;
        end else begin
            if (m_fifo) begin
                void'(q.pop_front());
                starve = 0;
            end else if (q.size() == 0) starve = 0;
            else if (m_win && starve < LIMIT) starve++;
            if (mcValid && push_ok) q.push_back('{r: mcReg, d: mcData});
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; wbValid = v.wv; wbReg = v.wr; wbData = v.wd;
        mcValid = v.mv; mcReg = v.mr; mcData = v.md;
        readRegister1 = v.r1; readRegister2 = v.r2;
    endtask

    function automatic vec_t mk(input logic rst, wv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic [4:0] r1, r2,
                                input logic we, input logic [4:0] ewr, input logic [31:0] ewd,
                                input logic st, rdy, h1, h2, cd, ch);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wr = wr; v.wd = wd; v.mv = mv; v.mr = mr; v.md = md;
        v.r1 = r1; v.r2 = r2; v.e_we = we; v.e_wr = ewr; v.e_wd = ewd;
        v.e_st = st; v.e_rdy = rdy; v.e_h1 = h1; v.e_h2 = h2; v.cd = cd; v.ch = ch;
        return v;
    endfunction

    initial begin
        //            rst wv wr wd            mv mr md     r1 r2 | we wr wd            st rdy h1 h2 cd ch
        vt.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            1, 7, 32'h11, 7, 0, 0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     7, 0,  1, 7, 32'h11,       0, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     7, 0,  0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 1, 100,          1, 3, 33,    3, 4,  1, 1, 100,          0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 2, 200,          1, 4, 44,    3, 4,  1, 2, 200,          0, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 1, 2, 201,          0, 0, 0,     3, 4,  1, 2, 201,          0, 0, 1, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 202,          0, 0, 0,     3, 4,  1, 2, 202,          0, 0, 1, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 203,          0, 0, 0,     3, 4,  1, 2, 203,          0, 0, 1, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 204,          0, 0, 0,     3, 4,  1, 3, 33,           1, 0, 1, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 204,          0, 0, 0,     3, 4,  1, 2, 204,          0, 1, 0, 1, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     3, 4,  1, 4, 44,           0, 1, 0, 1, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            1, 0, 55,    0, 0,  0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,            0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0,  0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 0, 77,           0, 0, 0,     0, 0,  0, 0, 0,            0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 1,            1, 8, 88,    8, 9,  1, 1, 1,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 1, 2,            1, 9, 99,    8, 9,  1, 1, 2,            0, 1, 1, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0,            0, 0, 0,     8, 9,  0, 0, 0,            0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     8, 9,  0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     8, 9,  0, 0, 0,            0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 1, 3,            1, 11, 32'hB, 11, 10, 1, 1, 3,          0, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            1, 10, 32'hA, 11, 10, 1, 11, 32'hB,     0, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     11, 10, 1, 10, 32'hA,      0, 1, 0, 1, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,     11, 10, 0, 0, 0,           0, 1, 0, 0, 1, 1));

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        #3;
        chk("rst_ready", {31'd0, mcReady}, 32'd1);
        chk("rst_we", {31'd0, regWrite}, 32'd0);
        chk("rst_stall", {31'd0, wbStall}, 32'd0);
        chk("rst_hits", {30'd0, pendingHit1, pendingHit2}, 32'd0);
        q.delete();
        starve = 0;

        foreach (vt[k]) begin
            logic rdy_before;
            apply(vt[k]);
            #3;
            model_eval();
            rdy_before = m_rdy;
            chk("vec_we", {31'd0, regWrite}, {31'd0, vt[k].e_we});
            chk("vec_wr", {27'd0, writeRegister}, {27'd0, vt[k].e_wr});
            if (vt[k].cd) chk("vec_wd", writeData, vt[k].e_wd);
            chk("vec_stall", {31'd0, wbStall}, {31'd0, vt[k].e_st});
            if (vt[k].ch) begin
                chk("vec_ready", {31'd0, mcReady}, {31'd0, vt[k].e_rdy});
                chk("vec_hit1", {31'd0, pendingHit1}, {31'd0, vt[k].e_h1});
                chk("vec_hit2", {31'd0, pendingHit2}, {31'd0, vt[k].e_h2});
            end
            @(posedge clk);
            #1;
            model_step(rdy_before);
            cyc++;
        end

        begin
            logic hold;
            hold = 0;
            for (int n = 0; n < 3000; n++) begin
                logic rdy_before;
                reset = ($urandom_range(0, 199) == 0);
                if (!hold) begin
                    wbValid = ($urandom_range(0, 3) != 0);
                    wbReg   = 5'($urandom_range(0, 7));
                    wbData  = $urandom;
                end
                mcValid = ($urandom_range(0, 2) == 0);
                mcReg   = 5'($urandom_range(0, 7));
                mcData  = $urandom;
                readRegister1 = 5'($urandom_range(0, 7));
                readRegister2 = 5'($urandom_range(0, 7));
                #3;
                model_eval();
                rdy_before = m_rdy;
                chk("rnd_we", {31'd0, regWrite}, {31'd0, m_we});
                chk("rnd_wr", {27'd0, writeRegister}, {27'd0, m_wr});
                if (m_we || !m_win) chk("rnd_wd", writeData, m_wd);
                chk("rnd_stall", {31'd0, wbStall}, {31'd0, m_st});
                if (!reset) begin
                    chk("rnd_ready", {31'd0, mcReady}, {31'd0, m_rdy});
                    chk("rnd_hit1", {31'd0, pendingHit1}, {31'd0, m_h1});
                    chk("rnd_hit2", {31'd0, pendingHit2}, {31'd0, m_h2});
                end
                hold = m_st;
                @(posedge clk);
                #1;
                model_step(rdy_before);
                cyc++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
